// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes and
// datapath select codes.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StIExec  = 4'd10,
        StIwb    = 4'd11,
        StTrap   = 4'd15
    } state_e;

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpOri   = 6'h0D;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;
    localparam logic [1:0] AluOr    = 2'b11;

    localparam logic [1:0] SrcBRt     = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    localparam logic [1:0] CauseNone    = 2'b00;
    localparam logic [1:0] CauseIllegal = 2'b01;
    localparam logic [1:0] CauseTimeout = 2'b10;

    function automatic logic is_mem_state(input state_e s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts stalled cycles and flags when MEM_TIMEOUT is reached.
module mc_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TMO_W       = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    logic [TMO_W-1:0] cnt_d, cnt_q;

    assign timeout_o = (cnt_q == TMO_W'(MEM_TIMEOUT));

    // Saturates at the limit so a held stall cannot wrap back below it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !timeout_o) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM with mem_ready handshake, wait timeout and trap.
// Define MC_PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module mc_controller
    import mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TMO_W       = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       Ext_op,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    state_e     state_q, state_d;
    logic       trap_d, trap_q;
    logic [1:0] trap_cause_d, trap_cause_q;
    logic       timeout;

    // ALU control decodes funct and the datapath gates branches on Zero.
    logic unused_inputs;
    assign unused_inputs = ^{funct, Zero};

    mc_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TMO_W      (TMO_W)
    ) u_wait_timer (
        .clk_i    (clock),
        .rst_i    (reset),
        .clr_i    (state_d != state_q),
        .en_i     (is_mem_state(state_q) && !mem_ready),
        .timeout_o(timeout)
    );

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode; else if (timeout) state_d = StTrap;
            StDecode: begin
                case (opcode)
                    OpLw, OpSw:     state_d = StMemAdr;
                    OpRType:        state_d = StExec;
                    OpBeq:          state_d = StBranch;
                    OpJ:            state_d = StJump;
                    OpAddi, OpOri:  state_d = StIExec;
                    default:        state_d = StTrap;
                endcase
            end
            StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) state_d = StMemWb; else if (timeout) state_d = StTrap;
            StMemWr:  if (mem_ready) state_d = StFetch; else if (timeout) state_d = StTrap;
            StExec:   state_d = StRwb;
            StIExec:  state_d = StIwb;
            StMemWb, StRwb, StBranch, StJump, StIwb: state_d = StFetch;
            default:  state_d = StTrap;
        endcase
    end

    always_comb begin : trap_next
        trap_d       = trap_q;
        trap_cause_d = trap_cause_q;
        if (state_d == StTrap && state_q != StTrap) begin
            trap_d       = 1'b1;
            trap_cause_d = (state_q == StDecode) ? CauseIllegal : CauseTimeout;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StFetch;
            trap_q       <= 1'b0;
            trap_cause_q <= CauseNone;
        end else begin
            state_q      <= state_d;
            trap_q       <= trap_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    always_comb begin : outputs
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SrcBRt;
        ALUOp       = AluAdd;
        PCSrc       = PcSrcAlu;
        Ext_op      = 1'b0;
        case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = SrcBFour;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            StDecode: begin
                ALUSrcB = SrcBImmSh2;
                Ext_op  = 1'b1;
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBImm;
                Ext_op  = 1'b1;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            StMemWb: begin
                MemtoReg = 1'b1;
                RegWrite = mem_ready;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            StExec: begin
                ALUSrcA = 1'b1;
                ALUOp   = AluFunct;
            end
            StRwb: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            StBranch: begin
                ALUSrcA     = 1'b1;
                ALUOp       = AluSub;
                PCSrc       = PcSrcAluOut;
                PCWriteCond = 1'b1;
            end
            StJump: begin
                PCSrc   = PcSrcJump;
                PCWrite = 1'b1;
            end
            StIExec: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBImm;
                if (opcode == OpOri) begin
                    ALUOp  = AluOr;
                    Ext_op = 1'b0;
                end else begin
                    Ext_op = 1'b1;
                end
            end
            StIwb:   RegWrite = 1'b1;
            default: ;
        endcase
        // No write of any kind may escape during the reset cycle.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    assign trap       = trap_q;
    assign trap_cause = trap_cause_q;
    assign state      = state_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_d, cycle_cnt_q, instr_cnt_d, instr_cnt_q;
    logic        from_terminal;

    always_comb begin
        from_terminal = (state_q == StMemWb) || (state_q == StMemWr) || (state_q == StRwb) ||
                        (state_q == StBranch) || (state_q == StJump) || (state_q == StIwb);
        cycle_cnt_d   = cycle_cnt_q + ((state_q != StTrap) ? 32'd1 : 32'd0);
        instr_cnt_d   = instr_cnt_q + ((from_terminal && state_d == StFetch) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: expected per-cycle outputs are queued as
// stimulus is driven and compared on the falling edge.
`timescale 1ns/1ps
module tb_mc_controller;
    import mc_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, Ext_op, trap;
    logic [1:0] ALUSrcB, ALUOp, PCSrc, trap_cause;
    logic [3:0] state;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    always #5 clock = ~clock;

    mc_controller #(
        .MEM_TIMEOUT(15),
        .TMO_W      (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSrc      (PCSrc),
        .Ext_op     (Ext_op),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state      (state)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    // Strobes: {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite}
    localparam logic [5:0] SNone      = 6'b000000;
    localparam logic [5:0] SFetchOk   = 6'b101010;
    localparam logic [5:0] SFetchWait = 6'b001000;
    localparam logic [5:0] SMemRd     = 6'b001000;
    localparam logic [5:0] SMemWr     = 6'b000100;
    localparam logic [5:0] SRegWr     = 6'b000001;
    localparam logic [5:0] SPcWr      = 6'b100000;
    localparam logic [5:0] SPcWrCond  = 6'b010000;

    // Selects: {IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Ext_op}
    localparam logic [10:0] DpFetch  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [10:0] DpDecode = {1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1};
    localparam logic [10:0] DpMemAdr = {1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b1};
    localparam logic [10:0] DpMemAcc = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [10:0] DpMemWb  = {1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [10:0] DpRwb    = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [10:0] DpIwb    = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [10:0] DpExec   = {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [10:0] DpBranch = {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [10:0] DpJump   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [10:0] DpAddi   = {1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b1};
    localparam logic [10:0] DpOri    = {1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 1'b0};

    localparam logic [10:0] MNone   = 11'b00000000000;
    localparam logic [10:0] MFetch  = 11'b10011111110;
    localparam logic [10:0] MImmAlu = 11'b00011111001;
    localparam logic [10:0] MMemAcc = 11'b10000000000;
    localparam logic [10:0] MWb     = 11'b01100000000;
    localparam logic [10:0] MExec   = 11'b00011111000;
    localparam logic [10:0] MBranch = 11'b00011111110;
    localparam logic [10:0] MJump   = 11'b00000000110;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [5:0]  strb;
        logic [10:0] dpv;
        logic [10:0] dpm;
        logic        trap;
        logic [1:0]  cause;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic       exp_trap = 1'b0;
    logic [1:0] exp_cause = 2'b00;
    logic [5:0]  strb_w;
    logic [10:0] dp_w;

    assign strb_w = {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite};
    assign dp_w   = {IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Ext_op};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_val({e.tag, ".state"}, 32'(state), 32'(e.st));
            check_val({e.tag, ".strobes"}, 32'(strb_w), 32'(e.strb));
            if (e.dpm != 11'd0) check_val({e.tag, ".selects"}, 32'(dp_w & e.dpm), 32'(e.dpv & e.dpm));
            check_val({e.tag, ".trap"}, 32'(trap), 32'(e.trap));
            check_val({e.tag, ".cause"}, 32'(trap_cause), 32'(e.cause));
        end
    end

    task automatic step(input string tag, input logic mr, input logic [3:0] st,
                        input logic [5:0] strb, input logic [10:0] dpv, input logic [10:0] dpm);
        exp_t e;
        mem_ready = mr;
        e.tag   = tag;
        e.st    = st;
        e.strb  = strb;
        e.dpv   = dpv;
        e.dpm   = dpm;
        e.trap  = exp_trap;
        e.cause = exp_cause;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch_decode(input string tag);
        step({tag, ".fetch"}, 1'b1, 4'd0, SFetchOk, DpFetch, MFetch);
        step({tag, ".decode"}, 1'b1, 4'd1, SNone, DpDecode, MImmAlu);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        step({tag, ".rst_a"}, 1'b1, state, SNone, DpFetch, MNone);
        exp_trap  = 1'b0;
        exp_cause = 2'b00;
        step({tag, ".rst_b"}, 1'b1, 4'd0, SNone, DpFetch, MNone);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(posedge clock);
        #1;
        step("reset", 1'b1, 4'd0, SNone, DpFetch, MNone);
        reset = 1'b0;

        opcode = OpLw;
        fetch_decode("lw");
        step("lw.adr", 1'b1, 4'd2, SNone, DpMemAdr, MImmAlu);
        step("lw.rd", 1'b1, 4'd3, SMemRd, DpMemAcc, MMemAcc);
        step("lw.wb", 1'b1, 4'd4, SRegWr, DpMemWb, MWb);

        opcode = OpBeq;
        Zero   = 1'b1;
        fetch_decode("beq1");
        step("beq1.br", 1'b1, 4'd8, SPcWrCond, DpBranch, MBranch);
        Zero = 1'b0;
        fetch_decode("beq0");
        step("beq0.br", 1'b1, 4'd8, SPcWrCond, DpBranch, MBranch);

        opcode = OpSw;
        fetch_decode("sw");
        step("sw.adr", 1'b1, 4'd2, SNone, DpMemAdr, MImmAlu);
        step("sw.wr", 1'b1, 4'd5, SMemWr, DpMemAcc, MMemAcc);

        opcode = OpRType;
        fetch_decode("rtype");
        step("rtype.exec", 1'b1, 4'd6, SNone, DpExec, MExec);
        step("rtype.wb", 1'b1, 4'd7, SRegWr, DpRwb, MWb);

        opcode = OpJ;
        fetch_decode("j");
        step("j.jump", 1'b1, 4'd9, SPcWr, DpJump, MJump);

        opcode = OpAddi;
        fetch_decode("addi");
        step("addi.exec", 1'b1, 4'd10, SNone, DpAddi, MImmAlu);
        step("addi.wb", 1'b1, 4'd11, SRegWr, DpIwb, MWb);

        opcode = OpOri;
        fetch_decode("ori");
        step("ori.exec", 1'b1, 4'd10, SNone, DpOri, MImmAlu);
        step("ori.wb", 1'b1, 4'd11, SRegWr, DpIwb, MWb);

        // Fetch stall: IRWrite/PCWrite only on the cycle mem_ready arrives.
        opcode = OpJ;
        for (int i = 0; i < 3; i++) begin
            step("stall.wait", 1'b0, 4'd0, SFetchWait, DpFetch, MFetch);
        end
        fetch_decode("stall");
        step("stall.jump", 1'b1, 4'd9, SPcWr, DpJump, MJump);

        // mem_ready arriving exactly at the limit completes the access.
        opcode = OpLw;
        fetch_decode("edge");
        step("edge.adr", 1'b1, 4'd2, SNone, DpMemAdr, MImmAlu);
        for (int i = 0; i < 15; i++) begin
            step("edge.wait", 1'b0, 4'd3, SMemRd, DpMemAcc, MMemAcc);
        end
        step("edge.done", 1'b1, 4'd3, SMemRd, DpMemAcc, MMemAcc);
        step("edge.wb", 1'b1, 4'd4, SRegWr, DpMemWb, MWb);

        // One more stalled cycle trips the timeout.
        fetch_decode("tmo");
        step("tmo.adr", 1'b1, 4'd2, SNone, DpMemAdr, MImmAlu);
        for (int i = 0; i < 16; i++) begin
            step("tmo.wait", 1'b0, 4'd3, SMemRd, DpMemAcc, MMemAcc);
        end
        exp_trap  = 1'b1;
        exp_cause = CauseTimeout;
        for (int i = 0; i < 3; i++) begin
            step("tmo.trap", 1'b1, 4'd15, SNone, DpFetch, MNone);
        end
        do_reset("tmo");

        opcode = 6'h3F;
        fetch_decode("ill");
        exp_trap  = 1'b1;
        exp_cause = CauseIllegal;
        step("ill.trap", 1'b1, 4'd15, SNone, DpFetch, MNone);
        step("ill.hold", 1'b0, 4'd15, SNone, DpFetch, MNone);
        do_reset("ill");

        // Reset mid-store: no MemWrite escapes while reset is held.
        opcode = OpSw;
        fetch_decode("mid");
        step("mid.adr", 1'b1, 4'd2, SNone, DpMemAdr, MImmAlu);
        reset = 1'b1;
        step("mid.rst", 1'b1, 4'd5, SNone, DpMemAcc, MNone);
        reset = 1'b0;
        step("mid.refetch", 1'b1, 4'd0, SFetchOk, DpFetch, MFetch);

`ifdef MC_PERF_CNT_EN
        do_reset("perf");
        opcode = OpOri;
        for (int i = 0; i < 2; i++) begin
            fetch_decode("perf");
            step("perf.exec", 1'b1, 4'd10, SNone, DpOri, MImmAlu);
            step("perf.wb", 1'b1, 4'd11, SRegWr, DpIwb, MWb);
        end
        check_val("perf.cycle_cnt", cycle_cnt, 32'd8);
        check_val("perf.instr_cnt", instr_cnt, 32'd2);
`endif

        @(negedge clock);
        #1;
        check_val("scoreboard.drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
